axis_pattern_master: RTL
========================

// Module: axis_pattern_master
// PURPOSE
//  AXI4-Stream transmitter: the source end of the stream our AXIS slave sinks.
//  On a start pulse it emits one packet of pkt_len beats of incrementing data, beginning at seed.
//  TLAST marks the final beat and full backpressure is honoured.
//  Used as traffic source for slave-side bring-up and as packet generator in the pipeline.
// PARAMETERS
//  C_M_AXIS_TDATA_WIDTH  32  TDATA width in bits (multiple of 8)
//  C_LEN_WIDTH           16  width of pkt_len and internal beat counter
//  C_CNT_WIDTH           16  width of pkt_count
// PORTS
//  M_AXIS_ACLK     in   1       clock, all logic on rising edge
//  M_AXIS_ARESETN  in   1       asynchronous reset, active low
//  start           in   1       request one packet; sampled only in IDLE
//  pkt_len         in   C_LEN_WIDTH  beats in packet; sampled with accepted start
//  seed            in   DW      data of first beat; sampled with accepted start
//  M_AXIS_TVALID   out  1       beat valid
//  M_AXIS_TDATA    out  DW      beat data (DW = C_M_AXIS_TDATA_WIDTH)
//  M_AXIS_TSTRB    out  DW/8    byte qualifiers, all ones while TVALID=1
//  M_AXIS_TLAST    out  1       final beat of packet
//  M_AXIS_TREADY   in   1       sink ready
//  busy            out  1       packet in progress (state STREAM)
//  done            out  1       one-cycle pulse after final beat accepted
//  pkt_count       out  C_CNT_WIDTH  completed packets, wraps modulo 2^C_CNT_WIDTH
// BEHAVIOUR
//  - One clock. Reset is asynchronous and active-low: M_AXIS_ARESETN=0 immediately forces all outputs to 0.
//    Affected: TVALID, TDATA, TSTRB, TLAST, busy, done, pkt_count. State forced to IDLE, beat counter to 0.
//  - All outputs registered. No combinational path from TREADY to any output.
//  - Handshake: beat transfers on a rising edge with TVALID=1 and TREADY=1.
//  - Once TVALID=1 it stays 1, and TDATA/TSTRB/TLAST stay stable, until that beat transfers.
//  - FSM IDLE: start=1 and pkt_len!=0 accepts the packet. Next cycle TVALID=1, TDATA=seed, TSTRB=all ones.
//    Same cycle: TLAST=(pkt_len==1), busy=1. Latency from start to first TVALID is 1 cycle.
//    start=1 with pkt_len==0 is ignored: no beat, no done, no count.
//  - FSM STREAM: start is ignored. On a handshake with TLAST=0: TDATA<=TDATA+1 (modulo 2^DW) and beat counter +1.
//    TLAST<=1 when the next beat is beat pkt_len-1 (0-based).
//  - Final-beat handshake (TLAST=1): next cycle TVALID=0, TLAST=0, TSTRB=0, busy=0, done=1 for one cycle.
//    pkt_count+1 (wraps), state returns to IDLE.
//  - TDATA holds its last value while TVALID=0. Sink must ignore it.
//  - start is sampled only in IDLE, so packets are separated by at least one TVALID=0 cycle.
//    start held high gives back-to-back packets with a 1-cycle gap.
//  - Changes to pkt_len/seed during STREAM have no effect on the current packet.
//  - Reset mid-packet aborts it: no TLAST, no done, pkt_count=0. The next start begins a fresh packet.
// TESTING
//  1. Reset; pkt_len=4, seed=0x10, start 1 cycle, TREADY=1.
//     Expect TDATA 0x10,0x11,0x12,0x13 on consecutive cycles, TLAST on 0x13 only.
//     Then done pulse, pkt_count=1, busy=0.
//  2. pkt_len=3, seed=0x100, TREADY toggling 0,1,0,1...
//     Expect TVALID/TDATA/TLAST stable during stalls and exactly 3 transfers (0x100..0x102).
//  3. pkt_len=1, seed=0xFFFFFFFF: single beat with TLAST=1.
//     Then pkt_len=3, seed=0xFFFFFFFE: beats 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 (wrap).
//  4. start with pkt_len=0: no TVALID, no done.
//     Also pulse start during busy: current packet unaffected and no extra packet follows.
//  5. Deassert M_AXIS_ARESETN mid-packet after beat 2 of 8.
//     Expect outputs 0 without waiting for a clock edge, and pkt_count=0.
//     Then pkt_len=2, seed=0 gives a normal packet 0x0, 0x1.
//  6. start held high, pkt_len=2, TREADY=1: repeated packets, each followed by exactly one idle cycle.
//     pkt_count increments once per packet.

Source files
------------

// File: rtl/axis_pattern_master.sv
// -----------------------------------------------------------------------------
// axis_pattern_master
//   AXI4-Stream source. A start pulse in IDLE launches one packet of pkt_len
//   beats. The data begins at seed and increments by one on every accepted
//   beat. TLAST marks the final beat, and backpressure through TREADY is
//   honoured.
//
// Ports
//   M_AXIS_ACLK     clock, rising edge
//   M_AXIS_ARESETN  asynchronous reset, active low; clears every output
//   start           request one packet (sampled only in IDLE)
//   pkt_len         beats in the packet, captured with an accepted start
//   seed            data of the first beat, captured with an accepted start
//   M_AXIS_TVALID   beat valid
//   M_AXIS_TDATA    beat data
//   M_AXIS_TSTRB    byte qualifiers, all ones while TVALID is high
//   M_AXIS_TLAST    final beat of the packet
//   M_AXIS_TREADY   sink ready
//   busy            packet in progress
//   done            one-cycle pulse after the final beat is accepted
//   pkt_count       completed packets, wraps
// -----------------------------------------------------------------------------
module axis_pattern_master #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_LEN_WIDTH          = 16,
  parameter int C_CNT_WIDTH          = 16
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  input  logic                              start,
  input  logic [C_LEN_WIDTH-1:0]            pkt_len,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   seed,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY,
  output logic                              busy,
  output logic                              done,
  output logic [C_CNT_WIDTH-1:0]            pkt_count
);

  localparam int DW = C_M_AXIS_TDATA_WIDTH;
  localparam int SW = C_M_AXIS_TDATA_WIDTH / 8;
  localparam int LW = C_LEN_WIDTH;
  localparam int CW = C_CNT_WIDTH;

  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_t;

  state_t state, state_nxt;

  // registered outputs and their next values
  logic          tvalid_q, tvalid_nxt;
  logic [DW-1:0] tdata_q,  tdata_nxt;
  logic [SW-1:0] tstrb_q,  tstrb_nxt;
  logic          tlast_q,  tlast_nxt;
  logic          busy_q,   busy_nxt;
  logic          done_q,   done_nxt;
  logic [CW-1:0] pcnt_q,   pcnt_nxt;

  // packet bookkeeping: index of the beat currently on the bus, and the
  // captured length so that later changes to pkt_len cannot disturb it
  logic [LW-1:0] beat_q,   beat_nxt;
  logic [LW-1:0] len_q,    len_nxt;

  logic          accept;
  logic          xfer;
  logic [LW-1:0] beat_inc;
  logic [LW-1:0] last_idx;

  // a zero-length request is dropped here, so STREAM never sees len_q == 0
  assign accept   = (state == S_IDLE) && start && (pkt_len != '0);
  assign xfer     = tvalid_q && M_AXIS_TREADY;
  assign beat_inc = beat_q + LW'(1);
  assign last_idx = len_q - LW'(1);

  // ---------------------------------------------------------------------------
  // state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) state <= S_IDLE;
    else                 state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept)            state_nxt = S_STREAM;
      S_STREAM: if (xfer && tlast_q)   state_nxt = S_IDLE;
      default:                         state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // output / datapath next values. Every output is computed here and then
  // registered, so TREADY never reaches a port combinationally.
  // ---------------------------------------------------------------------------
  always_comb begin
    tvalid_nxt = tvalid_q;
    tdata_nxt  = tdata_q;   // TDATA also holds through idle gaps
    tstrb_nxt  = tstrb_q;
    tlast_nxt  = tlast_q;
    busy_nxt   = busy_q;
    done_nxt   = 1'b0;
    pcnt_nxt   = pcnt_q;
    beat_nxt   = beat_q;
    len_nxt    = len_q;
    case (state)
      S_IDLE: begin
        if (accept) begin
          tvalid_nxt = 1'b1;
          tdata_nxt  = seed;
          tstrb_nxt  = '1;
          tlast_nxt  = (pkt_len == LW'(1));
          busy_nxt   = 1'b1;
          beat_nxt   = '0;
          len_nxt    = pkt_len;
        end
      end
      S_STREAM: begin
        if (xfer) begin
          if (tlast_q) begin
            tvalid_nxt = 1'b0;
            tstrb_nxt  = '0;
            tlast_nxt  = 1'b0;
            busy_nxt   = 1'b0;
            done_nxt   = 1'b1;
            pcnt_nxt   = pcnt_q + CW'(1);
            beat_nxt   = '0;
          end else begin
            tdata_nxt  = tdata_q + DW'(1);
            beat_nxt   = beat_inc;
            // raise TLAST as the last index is presented, not when it transfers
            tlast_nxt  = (beat_inc == last_idx);
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // output / datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pcnt_q   <= '0;
      beat_q   <= '0;
      len_q    <= '0;
    end else begin
      tvalid_q <= tvalid_nxt;
      tdata_q  <= tdata_nxt;
      tstrb_q  <= tstrb_nxt;
      tlast_q  <= tlast_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
      pcnt_q   <= pcnt_nxt;
      beat_q   <= beat_nxt;
      len_q    <= len_nxt;
    end
  end

  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TSTRB  = tstrb_q;
  assign M_AXIS_TLAST  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pkt_count     = pcnt_q;

endmodule
